// File: rtl/rs_en_latch_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_en_latch_if
//  Description : Enable/set/reset request bundle and registered Q/Qn return
//                for the gated RS latch bank.
//  Revision    : 1.0  initial release
// ============================================================================
interface rs_en_latch_if #(
    parameter int WIDTH = 1
);
    logic             C;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;

    modport master (
        output C,
        output S,
        output R,
        input  Q,
        input  Qn
    );

    modport slave (
        input  C,
        input  S,
        input  R,
        output Q,
        output Qn
    );
endinterface
`default_nettype wire

// File: rtl/rs_en_latch.sv
`default_nettype none
// ============================================================================
//  Module      : rs_en_latch
//  Description : Clock-sampled bank of enable-gated RS latches with registered
//                complementary outputs and reset-dominant forbidden-state exit.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_en_latch #(
    parameter int WIDTH = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rs_en_latch_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_CLR = 2'b00,
        ST_SET = 2'b01,
        ST_FBD = 2'b11
    } state_t;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            state_t r_state;
            state_t w_state_nxt;
            logic   r_q;
            logic   r_qn;

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    // Leaving Q=Qn=1 always lands on a defined state; only an
                    // explicit set request wins over the reset-dominant default.
                    ST_FBD: begin
                        if (bus.C && bus.S[i] && bus.R[i])
                            w_state_nxt = ST_FBD;
                        else if (bus.C && bus.S[i])
                            w_state_nxt = ST_SET;
                        else
                            w_state_nxt = ST_CLR;
                    end
                    ST_CLR, ST_SET: begin
                        if (bus.C) begin
                            if (bus.S[i] && bus.R[i])
                                w_state_nxt = ST_FBD;
                            else if (bus.S[i])
                                w_state_nxt = ST_SET;
                            else if (bus.R[i])
                                w_state_nxt = ST_CLR;
                        end
                    end
                    default: w_state_nxt = ST_CLR;
                endcase
            end

            // Outputs are decoded from the next state so Q/Qn come straight off flops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_CLR;
                    r_q     <= 1'b0;
                    r_qn    <= 1'b1;
                end else begin
                    r_state <= w_state_nxt;
                    r_q     <= (w_state_nxt != ST_CLR);
                    r_qn    <= (w_state_nxt != ST_SET);
                end
            end

            assign w_q[i]  = r_q;
            assign w_qn[i] = r_qn;
        end
    endgenerate

    assign bus.Q  = w_q;
    assign bus.Qn = w_qn;

endmodule
`default_nettype wire

// File: tb/tb_rs_en_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_en_latch
//  Description : Self-checking bench for rs_en_latch against a per-bit
//                behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_en_latch;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_qn;

    rs_en_latch_if #(.WIDTH(WIDTH)) bus ();

    rs_en_latch #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each bit is an independent latch described by its truth table.
    task automatic model_update(input logic r, input logic c,
                                input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] rr);
        for (int b = 0; b < WIDTH; b++) begin
            logic was_fbd;
            was_fbd = m_q[b] && m_qn[b];
            if (r) begin
                m_q[b] = 1'b0; m_qn[b] = 1'b1;
            end else if (c && s[b] && rr[b]) begin
                m_q[b] = 1'b1; m_qn[b] = 1'b1;
            end else if (c && s[b]) begin
                m_q[b] = 1'b1; m_qn[b] = 1'b0;
            end else if ((c && rr[b]) || was_fbd) begin
                m_q[b] = 1'b0; m_qn[b] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic c,
                        input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] rr);
        @(negedge clk);
        rst = r; bus.C = c; bus.S = s; bus.R = rr;
        @(posedge clk);
        #1;
        model_update(r, c, s, rr);
        chk("q",  32'(bus.Q),  32'(m_q));
        chk("qn", 32'(bus.Qn), 32'(m_qn));
    endtask

    function automatic logic [WIDTH-1:0] rep(input logic v);
        return {WIDTH{v}};
    endfunction

    initial begin
        logic [1:0] pats [5];
        m_q = '0; m_qn = '1;
        bus.C = 1'b0; bus.S = '0; bus.R = '0;
        pats[0] = 2'b10; pats[1] = 2'b01; pats[2] = 2'b11; pats[3] = 2'b00; pats[4] = 2'b10;

        // Reset wins over a concurrent set request
        step(1'b1, 1'b1, rep(1'b1), rep(1'b0));
        chk("rst_q",  32'(bus.Q),  32'h0);
        chk("rst_qn", 32'(bus.Qn), 32'hF);
        step(1'b1, 1'b1, rep(1'b1), rep(1'b0));

        // Set, then hold against reset requests while disabled
        step(1'b0, 1'b1, rep(1'b1), rep(1'b0));
        chk("set_q", 32'(bus.Q), 32'hF);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, rep(1'b0), rep(1'b1));
        chk("hold_q", 32'(bus.Q), 32'hF);

        // Reset request then hold
        step(1'b0, 1'b1, rep(1'b0), rep(1'b1));
        chk("clr_q", 32'(bus.Q), 32'h0);
        step(1'b0, 1'b1, rep(1'b0), rep(1'b0));

        // Forbidden entry and both exits
        step(1'b0, 1'b1, rep(1'b1), rep(1'b1));
        chk("fbd_q",  32'(bus.Q),  32'hF);
        chk("fbd_qn", 32'(bus.Qn), 32'hF);
        step(1'b0, 1'b1, rep(1'b0), rep(1'b0));
        chk("fbd_exit_q", 32'(bus.Q), 32'h0);
        step(1'b0, 1'b1, rep(1'b1), rep(1'b1));
        step(1'b0, 1'b0, rep(1'b1), rep(1'b1));
        chk("fbd_c0_q",  32'(bus.Q),  32'h0);
        chk("fbd_c0_qn", 32'(bus.Qn), 32'hF);

        // Toggling enable with stepped S/R patterns
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 100; k++) begin
                logic c;
                c = (((p * 100 + k) / 5) % 2) == 0;
                step(1'b0, c, rep(pats[p][1]), rep(pats[p][0]));
            end
        end
        chk("tog_final_q",  32'(bus.Q),  32'hF);
        chk("tog_final_qn", 32'(bus.Qn), 32'h0);

        // Mixed per-bit requests from a cleared bank
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 4'b0101, 4'b0011);
        chk("vec_q",  32'(bus.Q),  32'h5);
        chk("vec_qn", 32'(bus.Qn), 32'hB);
        step(1'b1, 1'b1, 4'b0101, 4'b0011);
        chk("midrst_q",  32'(bus.Q),  32'h0);
        chk("midrst_qn", 32'(bus.Qn), 32'hF);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom),
                 WIDTH'($urandom), WIDTH'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
